// File: rtl/riscv_pkg.sv
// Shared rv32i pipeline definitions: datapath width, canonical NOP and the
// fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,  // nothing outstanding
        WAIT,  // one request outstanding
        HOLD,  // instruction parked in the hold buffer under stall
        DROP   // wrong-path response still in flight, discard it
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory valid/ready request channel plus response channel.
// The fetch stage is the master; the memory is the slave.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            ImemReqValid;
    logic            ImemReqReady;
    logic [XLEN-1:0] ImemAddr;
    logic            ImemRspValid;
    logic [31:0]     ImemRspData;

    modport master (
        output ImemReqValid, ImemAddr,
        input  ImemReqReady, ImemRspValid, ImemRspData
    );

    modport slave (
        input  ImemReqValid, ImemAddr,
        output ImemReqReady, ImemRspValid, ImemRspData
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: async reset to RESET_PC, load enable, and a next-PC
// mux selecting between the sequential PC+4 and a redirect target.
module fetch_pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            sel_target_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    logic [XLEN-1:0] pc_q, pc_d;

    // Wraps modulo 2^XLEN by construction.
    assign pc_plus4_o = pc_q + XLEN'(4);
    assign pc_d       = sel_target_i ? target_i : pc_plus4_o;
    assign pc_o       = pc_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (en_i) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rv32i instruction-fetch stage: PC ownership, single-outstanding imem
// requests, stall hold buffer and redirect handling. Optional FETCH_MISALIGN_CHK_EN.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    fetch_stage_if.master    imem,
    output logic [XLEN-1:0]  PCF,
    output logic [XLEN-1:0]  PCPlus4F,
    output logic [31:0]      InstrF,
    output logic             FetchValidF,
    output logic             MisalignF
);

    fetch_state_t    state_q, state_d;
    logic [31:0]     hold_q, hold_d;
    logic            pc_en;
    logic            pc_sel_target;
    logic [XLEN-1:0] pc_target;

`ifdef FETCH_MISALIGN_CHK_EN
    assign pc_target = PCTargetE;
    assign MisalignF = (PCF[1:0] != 2'b00);
`else
    assign pc_target = PCTargetE & ~XLEN'(3);
    assign MisalignF = 1'b0;
`endif

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (rst),
        .en_i         (pc_en),
        .sel_target_i (pc_sel_target),
        .target_i     (pc_target),
        .pc_o         (PCF),
        .pc_plus4_o   (PCPlus4F)
    );

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d            = state_q;
        hold_d             = hold_q;
        imem.ImemReqValid  = 1'b0;
        imem.ImemAddr      = PCF;
        FetchValidF        = 1'b0;
        InstrF             = INSTR_NOP;
        pc_en              = 1'b0;
        pc_sel_target      = 1'b0;

        case (state_q)
            IDLE: begin
                if (PCSrcE) begin
                    pc_en         = 1'b1;
                    pc_sel_target = 1'b1;
                end else begin
                    imem.ImemReqValid = !MisalignF;
                    if (imem.ImemReqValid && imem.ImemReqReady) begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (imem.ImemRspValid) begin
                    FetchValidF = 1'b1;
                    InstrF      = imem.ImemRspData;
                    if (PCSrcE) begin
                        pc_en         = 1'b1;
                        pc_sel_target = 1'b1;
                        state_d       = IDLE;
                    end else if (StallF) begin
                        hold_d  = imem.ImemRspData;
                        state_d = HOLD;
                    end else begin
                        // Consume: advance and chain the next request this cycle.
                        pc_en             = 1'b1;
                        imem.ImemReqValid = !MisalignF;
                        imem.ImemAddr     = PCPlus4F;
                        state_d = (imem.ImemReqValid && imem.ImemReqReady) ? WAIT : IDLE;
                    end
                end else if (PCSrcE) begin
                    pc_en         = 1'b1;
                    pc_sel_target = 1'b1;
                    state_d       = DROP;
                end
            end

            HOLD: begin
                FetchValidF = 1'b1;
                InstrF      = hold_q;
                if (PCSrcE) begin
                    pc_en         = 1'b1;
                    pc_sel_target = 1'b1;
                    state_d       = IDLE;
                end else if (!StallF) begin
                    pc_en             = 1'b1;
                    imem.ImemReqValid = !MisalignF;
                    imem.ImemAddr     = PCPlus4F;
                    state_d = (imem.ImemReqValid && imem.ImemReqReady) ? WAIT : IDLE;
                end
            end

            DROP: begin
                // The in-flight response belongs to the old path; only its arrival matters.
                if (PCSrcE) begin
                    pc_en         = 1'b1;
                    pc_sel_target = 1'b1;
                end
                if (imem.ImemRspValid) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the one-entry hold buffer is reset to a NOP so it never holds an
    // undefined word; a real memory array would not need this.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= INSTR_NOP;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the rv32i pipeline. It owns the PC register, issues instruction-memory requests over a valid/ready interface with at most one request outstanding, and presents PCF/PCPlus4F/InstrF to the IF/ID register. It absorbs StallF with a one-entry hold buffer and applies PCSrcE redirects, discarding wrong-path responses.

## Interface
- XLEN, riscv_pkg::XLEN, datapath/PC width
- RESET_PC, '0, PC value loaded on reset
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- StallF  in  1  downstream not accepting; hold current fetch
- PCSrcE  in  1  redirect request from EX
- PCTargetE  in  XLEN  redirect target
- ImemReqValid  out  1  request valid
- ImemReqReady  in  1  memory accepts request
- ImemAddr  out  XLEN  request address
- ImemRspValid  in  1  response valid, at least 1 cycle after acceptance
- ImemRspData  in  32  response instruction word
- PCF  out  XLEN  address of instruction in F
- PCPlus4F  out  XLEN  PCF+4, modulo 2^XLEN
- InstrF  out  32  instruction; INSTR_NOP when FetchValidF=0
- FetchValidF  out  1  InstrF holds a real instruction; hazard unit ORs ~FetchValidF into FlushD
- MisalignF  out  1  PCF[1:0]!=0 (tied 0 without macro)

## Operation
- FSM, enum fetch_state_t: IDLE (nothing outstanding), WAIT (request outstanding), HOLD (instruction buffered under stall), DROP (discarding a wrong-path response).
- Consume = FetchValidF && !StallF && !PCSrcE.
- IDLE: ImemReqValid=!PCSrcE, ImemAddr=PCF. Accepted -> WAIT. PCSrcE -> PC<=PCTargetE, stay IDLE. FetchValidF=0. ImemRspValid ignored.
- WAIT, response this cycle: FetchValidF=1, InstrF=ImemRspData (combinational).
  - PCSrcE: discard, PC<=PCTargetE, -> IDLE.
  - StallF: hold<=ImemRspData, -> HOLD.
  - Consume: PC<=PCF+4; same cycle ImemReqValid=1, ImemAddr=PCF+4; accepted -> WAIT, else -> IDLE.
- WAIT, no response: FetchValidF=0. PCSrcE -> PC<=PCTargetE, -> DROP.
- HOLD: FetchValidF=1, InstrF=hold. PCSrcE -> PC<=PCTargetE, -> IDLE. Consume -> same as WAIT consume. StallF -> stay.
- DROP: FetchValidF=0, no request. ImemRspValid -> -> IDLE. PCSrcE -> PC<=PCTargetE, state unchanged unless ImemRspValid.
- Priority: PCSrcE > StallF > consume.
- ImemReqValid/ImemAddr stay stable until accepted, except on PCSrcE.

## Timing
- Reset (async assert, sync release): state IDLE, PCF=RESET_PC, hold=INSTR_NOP, FetchValidF=0, ImemReqValid=1 in the first cycle after release.
- Reset mid-operation abandons any outstanding request. The memory shares rst.
- 1-cycle memory, always ready, no stall: one instruction per cycle.
- Redirect: target request issued the cycle after PCSrcE. If a response is still in flight, it is issued after that response is discarded.
- ImemReqValid combinationally depends on ImemRspValid, StallF and PCSrcE. All state and PC updates are registered.

## Configuration
- FETCH_MISALIGN_CHK_EN defined: PC loads PCTargetE unmodified. MisalignF=PCF[1:0]!=0. ImemReqValid is suppressed while MisalignF=1, so fetch halts until a redirect to an aligned address.
- Undefined: PC loads {PCTargetE[XLEN-1:2],2'b00}. MisalignF tied 0.

## Structure
- riscv_pkg: XLEN, INSTR_NOP, fetch_state_t.
- Sub-module fetch_pc_reg: PC register with async reset to RESET_PC, enable, and next-PC mux (PCF+4 / PCTargetE).
- FSM and hold buffer are inline.

## Test plan
- Reset release, 1-cycle memory, ready=1: ImemAddr 0,4,8,… on consecutive cycles; FetchValidF=1 from cycle 2; PCPlus4F=PCF+4.
- StallF=1 for 3 cycles on instr at 0x8: InstrF and PCF held at 0x8; no new request; release -> request 0xC.
- PCSrcE with PCTargetE=0x100 while request outstanding: late response discarded (FetchValidF=0); next request addr 0x100.
- ImemReqReady=0 for 4 cycles: ImemReqValid=1 with ImemAddr stable until accepted.
- PCF=0xFFFFFFFC: PCPlus4F=0x0, next request addr 0x0.
- Macro on, PCTargetE=0x102: MisalignF=1, no request; redirect to 0x200 -> fetch resumes. Macro off: request addr 0x100.
